// File: rtl/spike_count_collector_pkg.sv
// -----------------------------------------------------------------------------
// spike_count_collector_pkg
//
// Purpose:
//   Shared sizing constants and types for the spike-count datapath. The
//   activation unit and the spike-count collector both import this package, so
//   the frame layout and the derived widths stay consistent between them.
//
// Contents:
//   NUM_LANES    neurons (lanes) per spike frame
//   TIMER_WIDTH  width of one spike count
//   FIFO_DEPTH   frames buffered by the collector (power of two, >= 2)
//   LANE_WIDTH   width of a lane index, never less than one bit
//   PTR_WIDTH    log2(FIFO_DEPTH)
//   FRAME_WIDTH  width of one packed frame, lane i at [i*TIMER_WIDTH +: TIMER_WIDTH]
//   beat_t       one outgoing lane beat as presented to the readout side
// -----------------------------------------------------------------------------
package spike_count_collector_pkg;

    localparam int NUM_LANES   = 3;
    localparam int TIMER_WIDTH = 5;
    localparam int FIFO_DEPTH  = 4;

    // $clog2(1) is 0, but a lane index still needs a physical bit, so the
    // result is clamped to one.
    function automatic int clog2Min1(input int value);
        int width;
        width = $clog2(value);
        return (width < 1) ? 1 : width;
    endfunction

    localparam int LANE_WIDTH  = clog2Min1(NUM_LANES);
    localparam int PTR_WIDTH   = $clog2(FIFO_DEPTH);
    localparam int FRAME_WIDTH = NUM_LANES * TIMER_WIDTH;

    typedef logic [TIMER_WIDTH-1:0] spike_count_t;

    typedef struct packed {
        logic                  valid;
        logic                  last;
        logic [LANE_WIDTH-1:0] lane;
        spike_count_t          count;
    } beat_t;

endpackage : spike_count_collector_pkg

// File: rtl/spike_count_collector_fifo.sv
// -----------------------------------------------------------------------------
// spike_frame_fifo
//
// Purpose:
//   Generic DEPTH x WIDTH register FIFO holding whole spike frames. The read
//   side exposes the head entry directly (first-word fall-through), so the
//   consumer can slice lanes out of the head frame without a read latency.
//
// Ports:
//   clk       in   system clock, rising edge
//   rstn      in   asynchronous active-low reset; empties the FIFO
//   push      in   write pushData this edge (ignored when full without pop)
//   pop       in   discard the head entry this edge (ignored when empty)
//   pushData  in   WIDTH-bit entry to write
//   full      out  all DEPTH entries occupied
//   empty     out  no entries occupied
//   count     out  number of occupied entries, 0..DEPTH
//   head      out  oldest entry (undefined content when empty)
// -----------------------------------------------------------------------------
module spike_frame_fifo
    import spike_count_collector_pkg::*;
#(
    parameter int DEPTH = FIFO_DEPTH,
    parameter int WIDTH = FRAME_WIDTH,
    parameter int PW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] pushData,
    output logic             full,
    output logic             empty,
    output logic [PW:0]      count,
    output logic [WIDTH-1:0] head
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW:0]      wrPtr_q, wrPtr_d;
    logic [PW:0]      rdPtr_q, rdPtr_d;
    logic             doPush;
    logic             doPop;

    // Pointers carry one extra wrap bit: equal pointers mean empty, equal
    // index bits with differing wrap bits mean full.
    assign empty = (wrPtr_q == rdPtr_q);
    assign full  = (wrPtr_q[PW] != rdPtr_q[PW]) &&
                   (wrPtr_q[PW-1:0] == rdPtr_q[PW-1:0]);
    assign count = wrPtr_q - rdPtr_q;
    assign head  = mem_q[rdPtr_q[PW-1:0]];

    // A push into a full FIFO is only legal when the head leaves on the same
    // edge; the write then lands in the slot being vacated.
    always_comb begin
        doPop   = pop && !empty;
        doPush  = push && (!full || doPop);
        wrPtr_d = wrPtr_q;
        rdPtr_d = rdPtr_q;
        if (doPush) begin
            wrPtr_d = wrPtr_q + 1'b1;
        end
        if (doPop) begin
            rdPtr_d = rdPtr_q + 1'b1;
        end
    end

    // Pointer registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
        end else begin
            wrPtr_q <= wrPtr_d;
            rdPtr_q <= rdPtr_d;
        end
    end

    // Frame storage; cleared on reset so the head reads as zero afterwards.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (doPush) begin
            mem_q[wrPtr_q[PW-1:0]] <= pushData;
        end
    end

endmodule : spike_frame_fifo

// File: rtl/spike_count_collector.sv
// -----------------------------------------------------------------------------
// spike_count_collector
//
// Purpose:
//   Sits downstream of the activation unit. On every capture strobe the
//   per-neuron spike counts of the finished interval are stored as one frame in
//   a small frame FIFO. Buffered frames are then streamed out one lane per beat
//   over a valid/ready interface, so interval cadence is decoupled from readout
//   back-pressure. A capture that finds no room is dropped and flagged through a
//   sticky overflow bit.
//
// Ports:
//   clk              in   system clock, rising edge
//   rstn             in   asynchronous active-low reset
//   capture          in   one-cycle strobe, spike_counts_in is final
//   spike_counts_in  in   NUM_LANES*TIMER_WIDTH, lane i at [i*TIMER_WIDTH +: TIMER_WIDTH]
//   out_valid        out  a beat is available
//   out_ready        in   consumer accepts the beat
//   out_count        out  spike count of the current lane
//   out_lane         out  lane index of the current beat
//   out_last         out  high on the beat for lane NUM_LANES-1
//   frames_pending   out  frames held, including the one being streamed
//   overflow         out  sticky, a capture was dropped
//   clear_overflow   in   synchronous clear of overflow (a same-edge drop wins)
//
// Every output is decoded from registers only; capture and out_ready only
// influence next-state logic.
// -----------------------------------------------------------------------------
module spike_count_collector
    import spike_count_collector_pkg::*;
#(
    parameter int NUM_LANES   = spike_count_collector_pkg::NUM_LANES,
    parameter int TIMER_WIDTH = spike_count_collector_pkg::TIMER_WIDTH,
    parameter int FIFO_DEPTH  = spike_count_collector_pkg::FIFO_DEPTH,
    parameter int PTR_WIDTH   = $clog2(FIFO_DEPTH),
    parameter int LANE_WIDTH  = clog2Min1(NUM_LANES)
) (
    input  logic                             clk,
    input  logic                             rstn,
    input  logic                             capture,
    input  logic [NUM_LANES*TIMER_WIDTH-1:0] spike_counts_in,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [TIMER_WIDTH-1:0]           out_count,
    output logic [LANE_WIDTH-1:0]            out_lane,
    output logic                             out_last,
    output logic [PTR_WIDTH:0]               frames_pending,
    output logic                             overflow,
    input  logic                             clear_overflow
);

    localparam int FW = NUM_LANES * TIMER_WIDTH;
    localparam logic [LANE_WIDTH-1:0] LAST_LANE = LANE_WIDTH'(NUM_LANES - 1);

    logic [LANE_WIDTH-1:0]  lane_q, lane_d;
    logic                   overflow_q, overflow_d;

    logic                   fifoFull;
    logic                   fifoEmpty;
    logic [PTR_WIDTH:0]     fifoCount;
    logic [FW-1:0]          headFrame;

    logic                   beatValid;
    logic                   laneIsLast;
    logic                   transfer;
    logic                   popFrame;
    logic                   acceptCapture;
    logic                   dropCapture;
    logic [TIMER_WIDTH-1:0] laneCount;

    spike_frame_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (FW),
        .PW    (PTR_WIDTH)
    ) u_frameFifo (
        .clk      (clk),
        .rstn     (rstn),
        .push     (acceptCapture),
        .pop      (popFrame),
        .pushData (spike_counts_in),
        .full     (fifoFull),
        .empty    (fifoEmpty),
        .count    (fifoCount),
        .head     (headFrame)
    );

    // Handshake decode. A full FIFO still accepts a capture when the last
    // beat of the head frame leaves on the same edge, freeing a slot.
    always_comb begin
        beatValid     = !fifoEmpty;
        laneIsLast    = (lane_q == LAST_LANE);
        transfer      = beatValid && out_ready;
        popFrame      = transfer && laneIsLast;
        acceptCapture = capture && (!fifoFull || popFrame);
        dropCapture   = capture && !acceptCapture;
    end

    // Lane counter: advances on each transfer, wraps to lane 0 with the pop.
    always_comb begin
        lane_d = lane_q;
        if (transfer) begin
            lane_d = laneIsLast ? '0 : lane_q + 1'b1;
        end
    end

    // Sticky overflow; a drop on the same edge as a clear keeps the flag set.
    always_comb begin
        overflow_d = overflow_q;
        if (dropCapture) begin
            overflow_d = 1'b1;
        end else if (clear_overflow) begin
            overflow_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            lane_q     <= '0;
            overflow_q <= 1'b0;
        end else begin
            lane_q     <= lane_d;
            overflow_q <= overflow_d;
        end
    end

    // Lane mux over the head frame, written as a compare loop so lane indices
    // beyond NUM_LANES-1 can never select outside the frame.
    always_comb begin
        laneCount = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            if (lane_q == LANE_WIDTH'(i)) begin
                laneCount = headFrame[i*TIMER_WIDTH +: TIMER_WIDTH];
            end
        end
    end

    // Beat fields are forced to zero while idle so a drained FIFO does not
    // expose a stale head frame.
    always_comb begin
        out_valid      = beatValid;
        out_count      = beatValid ? laneCount : '0;
        out_lane       = beatValid ? lane_q : '0;
        out_last       = beatValid && laneIsLast;
        frames_pending = fifoCount;
        overflow       = overflow_q;
    end

endmodule : spike_count_collector

// File: tb/tb_spike_count_collector.sv
// -----------------------------------------------------------------------------
// tb_spike_count_collector
//
// Directed bench for spike_count_collector. Stimulus pushes the beats each
// accepted frame should produce into an expected-beat queue; an independent
// monitor pops and compares whenever a beat transfers. Status outputs are
// compared directly at the points of interest.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_spike_count_collector;

    localparam int NL = 3;
    localparam int TW = 5;
    localparam int PW = 2;
    localparam int LW = 2;

    typedef struct {
        int lane;
        int count;
        int last;
    } beat_exp_t;

    logic              clk;
    logic              rstn;
    logic              capture;
    logic [NL*TW-1:0]  spikeCounts;
    logic              outValid;
    logic              outReady;
    logic [TW-1:0]     outCount;
    logic [LW-1:0]     outLane;
    logic              outLast;
    logic [PW:0]       framesPending;
    logic              overflow;
    logic              clearOverflow;

    beat_exp_t expQ[$];
    int checks = 0;
    int errors = 0;

    spike_count_collector dut (
        .clk             (clk),
        .rstn            (rstn),
        .capture         (capture),
        .spike_counts_in (spikeCounts),
        .out_valid       (outValid),
        .out_ready       (outReady),
        .out_count       (outCount),
        .out_lane        (outLane),
        .out_last        (outLast),
        .frames_pending  (framesPending),
        .overflow        (overflow),
        .clear_overflow  (clearOverflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    // Queue the three beats one frame should produce.
    task automatic pushFrame(input int c0, input int c1, input int c2);
        beat_exp_t b;
        b.lane = 0; b.count = c0; b.last = 0; expQ.push_back(b);
        b.lane = 1; b.count = c1; b.last = 0; expQ.push_back(b);
        b.lane = 2; b.count = c2; b.last = 1; expQ.push_back(b);
    endtask

    // One-cycle capture pulse; called at posedge+1, returns at the next posedge+1.
    // When expectAccept is set the frame's beats are queued for the monitor.
    task automatic applyStimulus(input int c0, input int c1, input int c2,
                                 input bit expectAccept, input bit clr);
        spikeCounts   = {TW'(c2), TW'(c1), TW'(c0)};
        capture       = 1'b1;
        clearOverflow = clr;
        if (expectAccept) pushFrame(c0, c1, c2);
        @(posedge clk); #1;
        capture       = 1'b0;
        clearOverflow = 1'b0;
    endtask

    task automatic waitCycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
        end
    endtask

    // Monitor: a beat transfers on the coming edge when valid && ready at the
    // negedge (inputs only change at posedge+1).
    initial begin
        beat_exp_t e;
        forever begin
            @(negedge clk);
            if (rstn && outValid && outReady) begin
                if (expQ.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_beat: got lane %0d count %0d, expected no beat at %0t",
                             outLane, outCount, $time);
                end else begin
                    e = expQ.pop_front();
                    checkOutput("beat_lane", int'(outLane), e.lane);
                    checkOutput("beat_count", int'(outCount), e.count);
                    checkOutput("beat_last", int'(outLast), e.last);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rstn          = 1'b0;
        capture       = 1'b0;
        spikeCounts   = '0;
        outReady      = 1'b0;
        clearOverflow = 1'b0;
        #22;
        checkOutput("rst_valid", int'(outValid), 0);
        checkOutput("rst_count", int'(outCount), 0);
        checkOutput("rst_lane", int'(outLane), 0);
        checkOutput("rst_last", int'(outLast), 0);
        checkOutput("rst_pending", int'(framesPending), 0);
        checkOutput("rst_overflow", int'(overflow), 0);
        rstn = 1'b1;
        @(posedge clk); #1;

        $display("[TB] single frame");
        outReady = 1'b1;
        applyStimulus(4, 0, 31, 1'b1, 1'b0);
        checkOutput("single_latency_valid", int'(outValid), 1);
        checkOutput("single_latency_lane", int'(outLane), 0);
        waitCycles(3);
        checkOutput("single_done_valid", int'(outValid), 0);
        checkOutput("single_queue_empty", expQ.size(), 0);

        $display("[TB] back-pressure");
        applyStimulus(7, 8, 9, 1'b1, 1'b0);
        waitCycles(1);
        outReady = 1'b0;
        for (int i = 0; i < 5; i++) begin
            waitCycles(1);
            checkOutput("bp_valid", int'(outValid), 1);
            checkOutput("bp_lane", int'(outLane), 1);
            checkOutput("bp_count", int'(outCount), 8);
        end
        outReady = 1'b1;
        waitCycles(3);
        checkOutput("bp_done_valid", int'(outValid), 0);
        checkOutput("bp_queue_empty", expQ.size(), 0);

        $display("[TB] fill");
        outReady = 1'b0;
        applyStimulus(1, 2, 3, 1'b1, 1'b0);
        applyStimulus(5, 6, 7, 1'b1, 1'b0);
        applyStimulus(10, 11, 12, 1'b1, 1'b0);
        applyStimulus(20, 21, 22, 1'b1, 1'b0);
        checkOutput("fill_pending", int'(framesPending), 4);
        checkOutput("fill_overflow", int'(overflow), 0);
        applyStimulus(30, 30, 30, 1'b0, 1'b0);
        checkOutput("drop_overflow", int'(overflow), 1);
        checkOutput("drop_pending", int'(framesPending), 4);
        clearOverflow = 1'b1;
        waitCycles(1);
        clearOverflow = 1'b0;
        checkOutput("clear_overflow", int'(overflow), 0);

        $display("[TB] full with simultaneous pop");
        outReady = 1'b1;
        waitCycles(2);
        checkOutput("fullpop_at_last", int'(outLast), 1);
        applyStimulus(13, 14, 15, 1'b1, 1'b0);
        outReady = 1'b0;
        checkOutput("fullpop_pending", int'(framesPending), 4);
        checkOutput("fullpop_overflow", int'(overflow), 0);
        checkOutput("fullpop_head_lane", int'(outLane), 0);
        checkOutput("fullpop_head_count", int'(outCount), 5);

        $display("[TB] overflow clear");
        applyStimulus(25, 26, 27, 1'b0, 1'b1);
        checkOutput("setwins_overflow", int'(overflow), 1);
        clearOverflow = 1'b1;
        waitCycles(1);
        clearOverflow = 1'b0;
        checkOutput("clear2_overflow", int'(overflow), 0);

        outReady = 1'b1;
        waitCycles(14);
        checkOutput("drain_pending", int'(framesPending), 0);
        checkOutput("drain_queue_empty", expQ.size(), 0);

        $display("[TB] reset mid-frame");
        applyStimulus(17, 18, 19, 1'b1, 1'b0);
        waitCycles(1);
        checkOutput("midrst_lane_before", int'(outLane), 1);
        expQ.delete();
        rstn = 1'b0;
        #1;
        checkOutput("midrst_valid", int'(outValid), 0);
        checkOutput("midrst_count", int'(outCount), 0);
        checkOutput("midrst_lane", int'(outLane), 0);
        checkOutput("midrst_pending", int'(framesPending), 0);
        #12;
        rstn = 1'b1;
        waitCycles(5);
        checkOutput("postrst_valid", int'(outValid), 0);
        checkOutput("postrst_pending", int'(framesPending), 0);
        applyStimulus(2, 4, 6, 1'b1, 1'b0);
        waitCycles(4);
        checkOutput("postrst_queue_empty", expQ.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_spike_count_collector
